seg_scan_ctrl: RTL and testbench

- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Shares one hex-to-segment decoder across all digits by scanning digit slots at a prescaled rate.
- Holds a frame-coherent shadow copy of the displayed value, loaded through a request/acknowledge handshake committed only at frame boundaries, so digits never tear.
- Sits between the machine's status/register logic and the board display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 18 +
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_ctrl.sv | 107 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// seg_scan_ctrl_pkg: shared segment constants and types for the scanned display.
// Rev 1.0
package seg_scan_ctrl_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] digit_idx_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low gfedcba patterns for hex 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// seg_scan_ctrl_if: load handshake and display pins of the scanned 7-segment controller.
// Rev 1.0
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                load;
  logic                busy;
  logic                load_ack;
  logic [DIGITS-1:0]   an_out;
  logic [7:0]          seg_out;

  modport master (
    output value_in, dp_in, blank_in, load,
    input  busy, load_ack, an_out, seg_out
  );

  modport slave (
    input  value_in, dp_in, blank_in, load,
    output busy, load_ack, an_out, seg_out
  );
endinterface
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// seg_hex_decode: hex nibble to active-low gfedcba segment pattern.
// Rev 1.0
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  nibble_t    hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// seg_scan_ctrl: multiplexed common-anode display driver with frame-coherent shadow load.
// Rev 1.0
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic           system1000,
  input  logic           system1000_rstn,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [SW-1:0]       slot;
  logic [4*DIGITS-1:0] shadow_value, stage_value;
  logic [DIGITS-1:0]   shadow_dp, stage_dp;
  logic [DIGITS-1:0]   shadow_blank, stage_blank;
  logic                pending;
  logic                ack;
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;

  logic                last_cnt;
  logic                frame_end;
  nibble_t             nib;
  logic [6:0]          dec;

  assign last_cnt  = (cnt == CNT_LAST);
  assign frame_end = last_cnt && (slot == SLOT_LAST);
  assign nib       = shadow_value[{slot, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .hex (nib),
    .seg (dec)
  );

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      cnt          <= '0;
      slot         <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      stage_value  <= '0;
      stage_dp     <= '0;
      stage_blank  <= '0;
      pending      <= 1'b0;
      ack          <= 1'b0;
      an           <= '1;
      seg          <= SEG_OFF;
    end else begin
      if (last_cnt) begin
        cnt  <= '0;
        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (bus.load) begin
        stage_value <= bus.value_in;
        stage_dp    <= bus.dp_in;
        stage_blank <= bus.blank_in;
      end

      // A load landing on the boundary itself bypasses staging so it is not lost.
      ack <= 1'b0;
      if (frame_end && (pending || bus.load)) begin
        if (bus.load) begin
          shadow_value <= bus.value_in;
          shadow_dp    <= bus.dp_in;
          shadow_blank <= bus.blank_in;
        end else begin
          shadow_value <= stage_value;
          shadow_dp    <= stage_dp;
          shadow_blank <= stage_blank;
        end
        pending <= 1'b0;
        ack     <= 1'b1;
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      if ((cnt < GUARD_CNT) || shadow_blank[slot]) begin
        an  <= '1;
        seg <= SEG_OFF;
      end else begin
        an  <= ~(DIGITS'(1) << slot);
        seg <= {~shadow_dp[slot], dec};
      end
    end
  end

  assign bus.busy     = pending;
  assign bus.load_ack = ack;
  assign bus.an_out   = an;
  assign bus.seg_out  = seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIGITS=4, PRESCALE=4, GUARD=1).
// Rev 1.0
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int FRAME  = 16;
  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } slot_t;

  logic  clk  = 1'b0;
  logic  rstn = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;
  slot_t sb[$];

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (4),
    .GUARD    (1)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    slot_t      e;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < DIGITS; k++) begin
      if (!bl[k]) begin
        e.an  = ~(one << k);
        e.seg = {~dp[k], TBL[v[4*k +: 4]]};
        sb.push_back(e);
      end
    end
  endfunction

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    int busy_low;
    n = 0;
    busy_low = 0;
    while (bus.load_ack !== 1'b1 && n < 4 * FRAME) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    check({tag, "_ack_seen"}, 32'(bus.load_ack), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_low), 32'd0);
    check({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  // Observes one full frame; every lit slot start is compared against the scoreboard.
  task automatic capture(input string tag);
    logic [3:0] prev;
    int         extra_ack;
    int         dark_bad;
    slot_t      e;
    prev = 4'hF;
    extra_ack = 0;
    dark_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) extra_ack++;
      if (bus.an_out === 4'hF) begin
        if (bus.seg_out !== 8'hFF) dark_bad++;
      end else if (bus.an_out !== prev) begin
        if (sb.size() == 0) begin
          check({tag, "_unexpected_slot"}, 32'(bus.an_out), 32'hF);
        end else begin
          e = sb.pop_front();
          check({tag, "_an"}, 32'(bus.an_out), 32'(e.an));
          check({tag, "_seg"}, 32'(bus.seg_out), 32'(e.seg));
        end
      end
      prev = bus.an_out;
    end
    check({tag, "_extra_ack"}, 32'(extra_ack), 32'd0);
    check({tag, "_dark_seg"}, 32'(dark_bad), 32'd0);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int lit;
    int acks;
    int busy_bad;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.load     = 1'b0;

    // Reset state and idle display
    repeat (3) @(negedge clk);
    check("rst_an", 32'(bus.an_out), 32'hF);
    check("rst_seg", 32'(bus.seg_out), 32'hFF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.load_ack), 32'd0);
    rstn = 1'b1;
    lit = 0;
    busy_bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.an_out !== 4'hF || bus.seg_out !== 8'hFF) lit++;
      if (bus.busy !== 1'b0) busy_bad++;
    end
    check("idle_dark", 32'(lit), 32'd0);
    check("idle_busy", 32'(busy_bad), 32'd0);

    // Single load
    drive_load(16'h3210, 4'h0, 4'h0);
    push_frame(16'h3210, 4'h0, 4'h0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_ack("t1");
    capture("t1");

    // Two loads in one frame: newest data, single ack
    drive_load(16'h1111, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    drive_load(16'hABCD, 4'h0, 4'h0);
    push_frame(16'hABCD, 4'h0, 4'h0);
    wait_ack("t2");
    capture("t2");

    // Pending request plus a load coincident with the frame boundary
    drive_load(16'h5555, 4'hF, 4'h0);
    check("t3_busy", 32'(bus.busy), 32'd1);
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) acks++;
    end
    check("t3_early_ack", 32'(acks), 32'd0);
    drive_load(16'h9876, 4'b1010, 4'h0);
    push_frame(16'h9876, 4'b1010, 4'h0);
    check("t3_ack", 32'(bus.load_ack), 32'd1);
    check("t3_busy_clr", 32'(bus.busy), 32'd0);
    capture("t3");

    // Blanked slot and decimal point
    drive_load(16'hF4E5, 4'b0001, 4'b0100);
    push_frame(16'hF4E5, 4'b0001, 4'b0100);
    wait_ack("t4");
    capture("t4");

    // Reset mid-slot with a pending request
    drive_load(16'h4321, 4'h0, 4'h0);
    @(negedge clk);
    check("t5_pending", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_rst_an", 32'(bus.an_out), 32'hF);
    check("t5_rst_seg", 32'(bus.seg_out), 32'hFF);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_ack", 32'(bus.load_ack), 32'd0);
    rstn = 1'b1;
    acks = 0;
    lit = 0;
    busy_bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) acks++;
      if (bus.an_out !== 4'hF || bus.seg_out !== 8'hFF) lit++;
      if (bus.busy !== 1'b0) busy_bad++;
    end
    check("t5_no_ack", 32'(acks), 32'd0);
    check("t5_dark", 32'(lit), 32'd0);
    check("t5_busy", 32'(busy_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
